// File: rtl/counter_pkg.sv
// Shared constants and helpers for the cascaded digit counter.
package counter_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned MAX_DIGITS = 8;
  localparam int unsigned MAX_RADIX  = 16;

  // Loaded digits beyond the radix saturate to the largest legal digit.
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d,
                                                     input int unsigned radix);
    logic [DIGIT_W-1:0] top;
    top = DIGIT_W'(radix - 1);
    return (d > top) ? top : d;
  endfunction

endpackage

// File: rtl/digit_counter.sv
// One radix-RADIX digit: parallel load with clamping, or a single up/down step.
module digit_counter
  import counter_pkg::*;
#(
  parameter int unsigned RADIX = 16
) (
  input  logic               clock,
  input  logic               clear_n,
  input  logic               step,
  input  logic               up_dn,
  input  logic               load,
  input  logic [DIGIT_W-1:0] ld_digit,
  output logic [DIGIT_W-1:0] digit,
  output logic               at_max,
  output logic               at_min
);

  localparam logic [DIGIT_W-1:0] TOP = DIGIT_W'(RADIX - 1);

  logic [DIGIT_W-1:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = clamp_digit(ld_digit, RADIX);
    end else if (step) begin
      if (up_dn) digit_d = (digit_q == TOP) ? '0 : digit_q + 1'b1;
      else       digit_d = (digit_q == '0) ? TOP : digit_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) digit_q <= '0;
    else          digit_q <= digit_d;
  end

  assign digit  = digit_q;
  assign at_max = (digit_q == TOP);
  assign at_min = (digit_q == '0);

endmodule

// File: rtl/multidigit_counter.sv
// Cascaded NUM_DIGITS-digit counter with wrap/saturate, terminal-count pulse and sticky overflow.
module multidigit_counter
  import counter_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned RADIX      = 16,
  localparam int unsigned W         = DIGIT_W * NUM_DIGITS
) (
  input  logic         clock,
  input  logic         clear_n,
  input  logic         enable,
  input  logic         up_dn,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         sat_mode,
  input  logic         clr_ovf,
  output logic [W-1:0] digits,
  output logic         tc,
  output logic         overflow
);

  if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
    $error("multidigit_counter: NUM_DIGITS must be 1..%0d", MAX_DIGITS);
  end
  if (RADIX < 2 || RADIX > MAX_RADIX) begin : g_bad_radix
    $error("multidigit_counter: RADIX must be 2..%0d", MAX_RADIX);
  end

  logic [NUM_DIGITS-1:0] at_max, at_min, step;
  logic                  evt;
  logic                  tc_q, tc_d;
  logic                  ovf_q, ovf_d;

  assign evt = enable & ~load & (up_dn ? (&at_max) : (&at_min));

  // A saturating event freezes every digit; otherwise the ripple chain wraps all digits together.
  always_comb begin
    logic run;
    logic base;
    step = '0;
    run  = 1'b1;
    base = enable & ~load & ~(evt & sat_mode);
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      step[i] = base & run;
      run     = run & (up_dn ? at_max[i] : at_min[i]);
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    digit_counter #(.RADIX(RADIX)) u_digit (
      .clock    (clock),
      .clear_n  (clear_n),
      .step     (step[g]),
      .up_dn    (up_dn),
      .load     (load),
      .ld_digit (load_value[DIGIT_W*g +: DIGIT_W]),
      .digit    (digits[DIGIT_W*g +: DIGIT_W]),
      .at_max   (at_max[g]),
      .at_min   (at_min[g])
    );
  end

  always_comb begin
    tc_d  = evt;
    ovf_d = evt | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign tc       = tc_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_multidigit_counter.sv
// Bench: RADIX=10 and RADIX=16 counters on shared stimulus, checked against value-level models.
module tb_multidigit_counter;

  logic        clock = 1'b0;
  logic        clear_n = 1'b0;
  logic        enable = 1'b0, up_dn = 1'b1, load = 1'b0, sat_mode = 1'b0, clr_ovf = 1'b0;
  logic [15:0] load_value = '0;
  logic [15:0] d10, d16;
  logic        tc10, tc16, ov10, ov16;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  multidigit_counter #(.NUM_DIGITS(4), .RADIX(10)) u10 (
    .clock(clock), .clear_n(clear_n), .enable(enable), .up_dn(up_dn), .load(load),
    .load_value(load_value), .sat_mode(sat_mode), .clr_ovf(clr_ovf),
    .digits(d10), .tc(tc10), .overflow(ov10));

  multidigit_counter #(.NUM_DIGITS(4), .RADIX(16)) u16 (
    .clock(clock), .clear_n(clear_n), .enable(enable), .up_dn(up_dn), .load(load),
    .load_value(load_value), .sat_mode(sat_mode), .clr_ovf(clr_ovf),
    .digits(d16), .tc(tc16), .overflow(ov16));

  // Model state: the count as a plain integer in 0..radix^4-1.
  int m10_val = 0, m16_val = 0;
  bit m10_tc = 0, m16_tc = 0, m10_ov = 0, m16_ov = 0;

  function automatic logic [15:0] to_packed(input int v, input int radix);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % radix);
      v = v / radix;
    end
    return r;
  endfunction

  function automatic int from_load(input logic [15:0] lv, input int radix);
    int v, d, w;
    v = 0;
    w = 1;
    for (int i = 0; i < 4; i++) begin
      d = int'(lv[4*i +: 4]);
      if (d >= radix) d = radix - 1;
      v = v + d * w;
      w = w * radix;
    end
    return v;
  endfunction

  task automatic model_step(input int radix, inout int val, inout bit t, inout bit ov);
    int  m;
    bit  ev;
    m = radix * radix * radix * radix;
    ev = 0;
    if (load) begin
      val = from_load(load_value, radix);
    end else if (enable) begin
      ev = up_dn ? (val == m - 1) : (val == 0);
      if (!ev)           val = up_dn ? val + 1 : val - 1;
      else if (!sat_mode) val = up_dn ? 0 : m - 1;
    end
    t  = ev;
    ov = ev | (ov & ~clr_ovf);
  endtask

  always @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      m10_val = 0; m10_tc = 0; m10_ov = 0;
      m16_val = 0; m16_tc = 0; m16_ov = 0;
    end else begin
      model_step(10, m10_val, m10_tc, m10_ov);
      model_step(16, m16_val, m16_tc, m16_ov);
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    check("r10 digits", d10, to_packed(m10_val, 10));
    check("r10 tc", 16'(tc10), 16'(m10_tc));
    check("r10 ovf", 16'(ov10), 16'(m10_ov));
    check("r16 digits", d16, to_packed(m16_val, 16));
    check("r16 tc", 16'(tc16), 16'(m16_tc));
    check("r16 ovf", 16'(ov16), 16'(m16_ov));
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit ld, input logic [15:0] lv, input bit en, input bit up,
                       input bit sat, input bit clr);
    load = ld; load_value = lv; enable = en; up_dn = up; sat_mode = sat; clr_ovf = clr;
  endtask

  initial begin
    cycle();
    check("lit reset digits", d10, 16'h0000);
    check("lit reset tc", 16'(tc10), 16'h0);
    clear_n = 1'b1;

    drive(1, 16'h0099, 0, 1, 0, 0); cycle();
    check("lit load 0099", d10, 16'h0099);
    drive(0, 16'h0000, 1, 1, 0, 0); cycle();
    check("lit 0099+1", d10, 16'h0100);
    check("lit 0099+1 tc", 16'(tc10), 16'h0);
    check("lit r16 0099+1", d16, 16'h009A);

    drive(1, 16'h9999, 0, 1, 0, 0); cycle();
    drive(0, 16'h0000, 1, 1, 0, 0); cycle();
    check("lit wrap digits", d10, 16'h0000);
    check("lit wrap tc", 16'(tc10), 16'h1);
    check("lit wrap ovf", 16'(ov10), 16'h1);
    drive(0, 16'h0000, 0, 1, 0, 0); cycle();
    check("lit tc drops", 16'(tc10), 16'h0);
    check("lit ovf sticky", 16'(ov10), 16'h1);
    drive(0, 16'h0000, 0, 1, 0, 1); cycle();
    check("lit ovf cleared", 16'(ov10), 16'h0);

    drive(1, 16'h9999, 0, 1, 1, 0); cycle();
    drive(0, 16'h0000, 1, 1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("lit sat digits", d10, 16'h9999);
      check("lit sat tc", 16'(tc10), 16'h1);
      check("lit sat ovf", 16'(ov10), 16'h1);
    end
    drive(0, 16'h0000, 0, 1, 0, 1); cycle();

    drive(1, 16'h0000, 0, 0, 0, 0); cycle();
    drive(0, 16'h0000, 1, 0, 0, 1); cycle();
    check("lit down wrap r10", d10, 16'h9999);
    check("lit down wrap r16", d16, 16'hFFFF);
    check("lit down tc", 16'(tc10), 16'h1);
    check("lit clr+event ovf", 16'(ov10), 16'h1);

    drive(1, 16'h12F4, 0, 1, 0, 0); cycle();
    check("lit clamp r10", d10, 16'h1294);
    check("lit noclamp r16", d16, 16'h12F4);
    drive(1, 16'h0005, 1, 1, 0, 0); cycle();
    check("lit load beats enable", d10, 16'h0005);

    drive(1, 16'h9999, 0, 1, 1, 0); cycle();
    drive(0, 16'h0000, 1, 1, 1, 0); cycle();
    #2 clear_n = 1'b0;
    #1;
    check("lit async rst digits", d10, 16'h0000);
    check("lit async rst tc", 16'(tc10), 16'h0);
    check("lit async rst ovf", 16'(ov10), 16'h0);
    #1 clear_n = 1'b1;
    cycle();
    check("lit resume from 0", d10, 16'h0001);

    for (int n = 0; n < 3000; n++) begin
      logic [15:0] lv;
      case ($urandom_range(3))
        0: lv = 16'h9999;
        1: lv = 16'h0000;
        2: lv = 16'hFFFF;
        default: lv = 16'($urandom);
      endcase
      drive($urandom_range(7) == 0, lv, $urandom_range(3) != 0, 1'($urandom),
            1'($urandom), $urandom_range(15) == 0);
      if ($urandom_range(199) == 0) begin
        #2 clear_n = 1'b0;
        #3 clear_n = 1'b1;
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
